// File: rtl/sig_pattern_gen_pkg.sv
// rtl/sig_pattern_gen_pkg.sv - shared state encoding and default constants for the test-signal generator
package sig_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_e;

  localparam logic [1:0] TESTMODE_SWEEP = 2'd3;

  // Defaults assume a 48 MHz sysclk: 1 Hz, 1 kHz, 1 MHz.
  localparam int unsigned DEF_HALF0        = 24_000_000;
  localparam int unsigned DEF_HALF1        = 24_000;
  localparam int unsigned DEF_HALF2        = 24;
  localparam int unsigned DEF_SWEEP_CYCLES = 4;
  localparam int unsigned DEF_CW           = 25;

endpackage

// File: rtl/sig_pattern_gen_sync2.sv
// rtl/sig_pattern_gen_sync2.sv - two-flop synchronizer for slow asynchronous inputs
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sig_pattern_gen.sv
// rtl/sig_pattern_gen.sv - square-wave test-signal generator with fixed and swept frequencies
// Frequency selection is committed only at period boundaries so sigin never carries a runt pulse.
module sig_pattern_gen
  import sig_pattern_gen_pkg::*;
#(
  parameter int unsigned HALF0        = DEF_HALF0,
  parameter int unsigned HALF1        = DEF_HALF1,
  parameter int unsigned HALF2        = DEF_HALF2,
  parameter int unsigned SWEEP_CYCLES = DEF_SWEEP_CYCLES,
  parameter int unsigned CW           = DEF_CW
) (
  input  logic       sysclk_i,
  input  logic       resetb_i,
  input  logic [1:0] testmode_i,
  input  logic       gen_en_i,
  output logic       sigin_o,
  output logic       rise_pulse_o,
  output logic [1:0] active_sel_o,
  output logic       running_o
);

  localparam int SCW = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;

  logic [1:0]     tm_sync;
  logic           gen_sync;
  gen_state_e     state_q;
  logic [CW-1:0]  hcnt_q;
  logic [SCW-1:0] sweep_cnt_q;
  logic           sweep_mode_q;
  logic [1:0]     active_sel_q;
  logic           sigin_q;
  logic           rise_q;
  logic           running_q;

  logic [1:0]     sel_d;
  logic [SCW-1:0] sweep_cnt_d;
  logic           sweep_mode_d;
  logic           boundary;
  logic           start;

  sync2 #(.W(2)) u_sync_tm (
    .clk_i (sysclk_i),
    .rst_i (resetb_i),
    .d_i   (testmode_i),
    .q_o   (tm_sync)
  );

  sync2 #(.W(1)) u_sync_en (
    .clk_i (sysclk_i),
    .rst_i (resetb_i),
    .d_i   (gen_en_i),
    .q_o   (gen_sync)
  );

  function automatic logic [CW-1:0] half_m1(input logic [1:0] sel);
    case (sel)
      2'd1:    return CW'(HALF1 - 1);
      2'd2:    return CW'(HALF2 - 1);
      default: return CW'(HALF0 - 1);
    endcase
  endfunction

  assign boundary = (state_q == LOW) && (hcnt_q == '0);
  assign start    = ((state_q == IDLE) || boundary) && gen_sync;

  // Selection to commit at the next period start; a resumed sweep keeps its position.
  always_comb begin
    sel_d        = tm_sync;
    sweep_cnt_d  = '0;
    sweep_mode_d = 1'b0;
    if (tm_sync == TESTMODE_SWEEP) begin
      sweep_mode_d = 1'b1;
      if (!sweep_mode_q) begin
        sel_d = 2'd0;
      end else if (state_q == IDLE) begin
        sel_d       = active_sel_q;
        sweep_cnt_d = sweep_cnt_q;
      end else if (sweep_cnt_q == SCW'(SWEEP_CYCLES - 1)) begin
        sel_d = (active_sel_q == 2'd2) ? 2'd0 : active_sel_q + 2'd1;
      end else begin
        sel_d       = active_sel_q;
        sweep_cnt_d = sweep_cnt_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (resetb_i) begin
      state_q      <= IDLE;
      hcnt_q       <= half_m1(2'd0);
      sweep_cnt_q  <= '0;
      sweep_mode_q <= 1'b0;
      active_sel_q <= 2'd0;
      sigin_q      <= 1'b0;
      rise_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      rise_q    <= 1'b0;
      running_q <= (state_q != IDLE) | gen_sync;
      if (start) begin
        state_q      <= HIGH;
        sigin_q      <= 1'b1;
        rise_q       <= 1'b1;
        active_sel_q <= sel_d;
        sweep_cnt_q  <= sweep_cnt_d;
        sweep_mode_q <= sweep_mode_d;
        hcnt_q       <= half_m1(sel_d);
      end else begin
        case (state_q)
          HIGH: begin
            if (hcnt_q == '0) begin
              state_q <= LOW;
              sigin_q <= 1'b0;
              hcnt_q  <= half_m1(active_sel_q);
            end else begin
              hcnt_q <= hcnt_q - CW'(1);
            end
          end
          LOW: begin
            if (hcnt_q == '0) begin
              state_q <= IDLE;
              sigin_q <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q - CW'(1);
            end
          end
          IDLE: sigin_q <= 1'b0;
          default: begin
            state_q <= IDLE;
            sigin_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (!resetb_i) begin
      assert (HALF0 >= 1 && HALF1 >= 1 && HALF2 >= 1)
        else $error("sig_pattern_gen: every HALFn must be at least 1");
    end
  end

  assign sigin_o      = sigin_q;
  assign rise_pulse_o = rise_q;
  assign active_sel_o = active_sel_q;
  assign running_o    = running_q;

endmodule

// File: tb/tb_sig_pattern_gen.sv
// tb/tb_sig_pattern_gen.sv - scoreboard bench for sig_pattern_gen
module tb_sig_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tm;
  logic       gen_en;
  logic       sigin;
  logic       rise_pulse;
  logic [1:0] active_sel;
  logic       running;

  typedef struct {
    int sel;
    int half;
  } exp_t;

  exp_t exp_q[$];
  int   halfs[3] = '{2, 3, 5};
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   mon_busy = 1'b0;

  exp_t mon_e;
  int   mon_bad;
  bit   mon_abort;

  sig_pattern_gen #(
    .HALF0(2), .HALF1(3), .HALF2(5), .SWEEP_CYCLES(2), .CW(4)
  ) dut (
    .sysclk_i    (clk),
    .resetb_i    (rst),
    .testmode_i  (tm),
    .gen_en_i    (gen_en),
    .sigin_o     (sigin),
    .rise_pulse_o(rise_pulse),
    .active_sel_o(active_sel),
    .running_o   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic push_exp(input int sel);
    exp_t e;
    e.sel  = sel;
    e.half = halfs[sel];
    exp_q.push_back(e);
  endtask

  task automatic wait_rise(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rise_pulse !== 1'b1 && n < 60);
    check(name, int'(rise_pulse === 1'b1), 1);
  endtask

  // Monitor: each rise pops one expected period and checks its sel and full high/low shape.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rise_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rise", 1, 0);
        end else begin
          mon_e     = exp_q.pop_front();
          mon_busy  = 1'b1;
          mon_abort = 1'b0;
          mon_bad   = (sigin !== 1'b1) ? 1 : 0;
          check("active_sel", int'(active_sel), mon_e.sel);
          for (int k = 1; k < 2 * mon_e.half; k++) begin
            @(negedge clk);
            if (rst) begin
              mon_abort = 1'b1;
              break;
            end
            if (sigin !== (k < mon_e.half) || rise_pulse !== 1'b0) mon_bad++;
          end
          if (!mon_abort) check("period_shape", mon_bad, 0);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int hi;
    rst = 1'b1; tm = 2'd0; gen_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sigin", int'(sigin), 0);
    check("reset_rise", int'(rise_pulse), 0);
    check("reset_sel", int'(active_sel), 0);
    check("reset_running", int'(running), 0);

    // 1: release with gen_en=1, mode 0; first rise 3 cycles later
    repeat (3) push_exp(0);
    #1 rst = 1'b0; gen_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sigin !== 1'b1 && n < 10);
    check("first_rise_latency", n, 3);
    wait_rise("rise_p2");
    wait_rise("rise_p3");

    // 2: switch to mode 2 during HIGH of the third period
    #1 tm = 2'd2;
    push_exp(2);
    push_exp(2);
    wait_rise("rise_sel2_a");
    wait_rise("rise_sel2_b");

    // 3: sweep for 20 periods
    #1 tm = 2'd3;
    for (int i = 0; i < 20; i++) push_exp((i / 2) % 3);
    for (int i = 0; i < 20; i++) wait_rise("rise_sweep");

    // 4: HALF1 period, gen_en dropped one cycle after its rise
    #1 tm = 2'd1;
    push_exp(1);
    wait_rise("rise_sel1");
    @(negedge clk);
    #1 gen_en = 1'b0;
    repeat (5) @(negedge clk);
    check("running_last_low", int'(running), 1);
    @(negedge clk);
    check("running_fell", int'(running), 0);
    check("idle_sigin", int'(sigin), 0);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      hi += int'(sigin);
    end
    check("idle_quiet", hi, 0);

    // 5: reset in the middle of a HALF2 HIGH half
    #1 tm = 2'd2; gen_en = 1'b1;
    push_exp(2);
    wait_rise("rise_before_reset");
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midreset_sigin", int'(sigin), 0);
    check("midreset_sel", int'(active_sel), 0);
    check("midreset_rise", int'(rise_pulse), 0);
    check("midreset_running", int'(running), 0);
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      hi += int'(sigin) + int'(rise_pulse);
    end
    check("reset_hold_quiet", hi, 0);
    #1 rst = 1'b0; gen_en = 1'b0; tm = 2'd1;
    repeat (4) @(negedge clk);
    check("post_reset_queue", exp_q.size(), 0);

    // 6: mode 1 -> 2 -> 1 inside one period must not alter the next period
    #1 gen_en = 1'b1;
    repeat (3) push_exp(1);
    wait_rise("rise_m1_a");
    #1 tm = 2'd2;
    @(negedge clk);
    #1 tm = 2'd1;
    wait_rise("rise_m1_b");
    wait_rise("rise_m1_c");
    #1 gen_en = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_running", int'(running), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
